stream_to_block: RTL and testbench

//  Parametrised byte-stream deserializer feeding the SEED core from external GPIO (Raspberry Pi).

---
 rtl/seed_pkg.sv | 13 +
 rtl/pin_edge_sync.sv | 27 ++
 rtl/stream_to_block.sv | 127 ++++++++++++
 tb/tb_stream_to_block.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seed_pkg.sv
// Shared definitions for the SEED cipher front end: block/key widths and the
// pin deserializer's frame state.
package seed_pkg;

    localparam int SEED_BLOCK_W = 128;
    localparam int SEED_KEY_W   = 128;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

endpackage

// File: rtl/pin_edge_sync.sv
// Brings an asynchronous GPIO strobe into the clk domain and turns each rising
// edge into a single-cycle pulse, however long the pin stays high.
module pin_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pulse = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/stream_to_block.sv
// Deserializes MSB-first pin words from the GPIO header into one block and
// offers it to the cipher on a valid/ready handshake, split into plaintext and key.
module stream_to_block
    import seed_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int BLOCK_BYTES = 32,
    parameter int KEY_BYTES   = 16,
    parameter int SYNC_STAGES = 2,
    parameter int NEED_START  = 1
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    in_en,
    input  logic                                    start1,
    input  logic                                    load1,
    input  logic [DATA_W-1:0]                       part_msg1,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [(BLOCK_BYTES-KEY_BYTES)*DATA_W-1:0] plaintext,
    output logic [KEY_BYTES*DATA_W-1:0]             key,
    output logic                                    short_err,
    output logic                                    ovr_err,
    input  logic                                    err_clr
);

    localparam int BLOCK_W = BLOCK_BYTES * DATA_W;
    localparam int KEY_W   = KEY_BYTES * DATA_W;
    localparam int PT_W    = BLOCK_W - KEY_W;
    localparam int CNT_W   = $clog2(BLOCK_BYTES);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(BLOCK_BYTES - 1);
    localparam state_t           RST_STATE = (NEED_START != 0) ? IDLE : COLLECT;

    logic start_pulse, load_pulse;

    pin_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_start_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (start1),
        .pulse    (start_pulse)
    );

    pin_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_load_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (load1),
        .pulse    (load_pulse)
    );

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d, widx;
    logic [BLOCK_W-1:0] asm_q, asm_d;
    logic [BLOCK_W-1:0] out_q, out_d;
    logic               vld_q, vld_d;
    logic               short_q, short_d;
    logic               ovr_q, ovr_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RST_STATE;
            count_q <= '0;
            asm_q   <= '0;
            out_q   <= '0;
            vld_q   <= 1'b0;
            short_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            asm_q   <= asm_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
            short_q <= short_d;
            ovr_q   <= ovr_d;
        end
    end

    // Ordering inside the enabled branch matters: clear before set so a set
    // condition wins, and start before load so a coincident word lands as word 0.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        asm_d   = asm_q;
        out_d   = out_q;
        vld_d   = vld_q;
        short_d = short_q;
        ovr_d   = ovr_q;
        widx    = count_q;
        if (in_en) begin
            if (err_clr) begin
                short_d = 1'b0;
                ovr_d   = 1'b0;
            end
            if (vld_q && out_ready)
                vld_d = 1'b0;
            if (start_pulse) begin
                if (state_q == COLLECT && count_q != '0)
                    short_d = 1'b1;
                state_d = COLLECT;
                count_d = '0;
                asm_d   = '0;
                widx    = '0;
            end
            if (load_pulse && (start_pulse || state_q == COLLECT)) begin
                asm_d[(BLOCK_BYTES - 1 - int'(widx)) * DATA_W +: DATA_W] = part_msg1;
                if (widx == LAST_IDX) begin
                    count_d = '0;
                    if (!vld_q || out_ready) begin
                        out_d = asm_d;
                        vld_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else begin
                    count_d = widx + CNT_W'(1);
                end
            end
        end
    end

    assign out_valid = vld_q;
    assign plaintext = out_q[BLOCK_W-1 -: PT_W];
    assign key       = out_q[KEY_W-1:0];
    assign short_err = short_q;
    assign ovr_err   = ovr_q;

endmodule

// File: tb/tb_stream_to_block.sv
// Randomized scenario bench for stream_to_block: a default instance plus a
// NEED_START=0 / 16-word instance, both checked against a shift-in block model.
module tb_stream_to_block;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_en;
    logic         start1;
    logic         load1;
    logic [7:0]   part_msg1;
    logic         out_ready;
    logic         err_clr;

    logic         out_valid, short_err, ovr_err;
    logic [127:0] plaintext, key;
    logic         out_valid2, short_err2, ovr_err2;
    logic [63:0]  plaintext2, key2;

    int checks   = 0;
    int failures = 0;

    // Model: a block is simply the last N words since the frame began, first word on top.
    logic [255:0] exp_blk;
    logic [127:0] exp_blk2;

    always #5 clk = ~clk;

    stream_to_block dut (
        .clk(clk), .reset_n(reset_n), .in_en(in_en), .start1(start1), .load1(load1),
        .part_msg1(part_msg1), .out_valid(out_valid), .out_ready(out_ready),
        .plaintext(plaintext), .key(key), .short_err(short_err), .ovr_err(ovr_err),
        .err_clr(err_clr)
    );

    stream_to_block #(.NEED_START(0), .BLOCK_BYTES(16), .KEY_BYTES(8)) dut2 (
        .clk(clk), .reset_n(reset_n), .in_en(in_en), .start1(start1), .load1(load1),
        .part_msg1(part_msg1), .out_valid(out_valid2), .out_ready(out_ready),
        .plaintext(plaintext2), .key(key2), .short_err(short_err2), .ovr_err(ovr_err2),
        .err_clr(err_clr)
    );

    task automatic send_word(input logic [7:0] w, input int hi, input int gap, input bit counted);
        @(negedge clk);
        part_msg1 = w;
        load1 = 1'b1;
        repeat (hi) @(negedge clk);
        load1 = 1'b0;
        repeat (gap) @(negedge clk);
        if (counted) begin
            exp_blk  = {exp_blk[247:0], w};
            exp_blk2 = {exp_blk2[119:0], w};
        end
    endtask

    task automatic send_start();
        @(negedge clk);
        start1 = 1'b1;
        repeat (2) @(negedge clk);
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        exp_blk  = '0;
        exp_blk2 = '0;
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic clear_errs();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, short_err, ovr_err, plaintext, key} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b s=%b o=%b pt=%h key=%h exp all zero",
                     out_valid, short_err, ovr_err, plaintext, key);
        end
        checks++;
        if ({out_valid2, short_err2, ovr_err2, plaintext2, key2} !== '0) begin
            failures++;
            $display("FAIL reset_outputs_dut2 got v=%b pt=%h key=%h exp all zero",
                     out_valid2, plaintext2, key2);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        send_start();
        for (int k = 0; k < 31; k++) send_word(8'(k), 2, 2, 1'b1);
        @(negedge clk);
        part_msg1 = 8'h1F;
        load1 = 1'b1;
        @(negedge clk);
        load1 = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_valid_early got=%b exp=0", out_valid);
        end
        @(negedge clk);
        exp_blk = {exp_blk[247:0], 8'h1F};
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL basic_valid_latency got=%b exp=1", out_valid);
        end
        checks++;
        if (plaintext !== 128'h000102030405060708090A0B0C0D0E0F ||
            key !== 128'h101112131415161718191A1B1C1D1E1F) begin
            failures++;
            $display("FAIL basic_block got pt=%h key=%h exp pt=000102..0F key=101112..1F", plaintext, key);
        end
        consume();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_transfer got valid=%b exp=0", out_valid);
        end
    endtask

    task automatic test_long_hold();
        send_start();
        for (int k = 0; k < 32; k++) send_word(8'(k), 50, 3, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || plaintext !== 128'h000102030405060708090A0B0C0D0E0F ||
            key !== 128'h101112131415161718191A1B1C1D1E1F || short_err !== 1'b0) begin
            failures++;
            $display("FAIL long_hold got v=%b s=%b pt=%h key=%h exp v=1 s=0 same block as basic",
                     out_valid, short_err, plaintext, key);
        end
        consume();
    endtask

    task automatic test_short_frame();
        send_start();
        for (int k = 0; k < 10; k++) send_word(8'($urandom), 2, 2, 1'b1);
        send_start();
        for (int k = 0; k < 32; k++) send_word(8'(8'hA0 + k), 2, 2, 1'b1);
        checks++;
        if (short_err !== 1'b1) begin
            failures++;
            $display("FAIL short_err_set got=%b exp=1", short_err);
        end
        checks++;
        if (out_valid !== 1'b1 || {plaintext, key} !== exp_blk) begin
            failures++;
            $display("FAIL short_block got v=%b blk=%h exp=%h", out_valid, {plaintext, key}, exp_blk);
        end
        consume();
        clear_errs();
        checks++;
        if (short_err !== 1'b0) begin
            failures++;
            $display("FAIL short_err_clear got=%b exp=0", short_err);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] w0;
        send_start();
        for (int k = 0; k < 5; k++) send_word(8'($urandom), 2, 2, 1'b1);
        w0 = 8'($urandom);
        @(negedge clk);
        start1 = 1'b1;
        load1 = 1'b1;
        part_msg1 = w0;
        repeat (2) @(negedge clk);
        start1 = 1'b0;
        load1 = 1'b0;
        repeat (3) @(negedge clk);
        exp_blk = {248'b0, w0};
        for (int k = 0; k < 31; k++) send_word(8'($urandom), 2, 2, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || short_err !== 1'b1 || {plaintext, key} !== exp_blk) begin
            failures++;
            $display("FAIL simultaneous got v=%b s=%b blk=%h exp v=1 s=1 blk=%h",
                     out_valid, short_err, {plaintext, key}, exp_blk);
        end
        consume();
        clear_errs();
    endtask

    task automatic test_overrun();
        logic [255:0] first;
        out_ready = 1'b0;
        send_start();
        for (int k = 0; k < 32; k++) send_word(8'($urandom), 2, 2, 1'b1);
        first = exp_blk;
        checks++;
        if (ovr_err !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL ovr_first got v=%b o=%b exp v=1 o=0", out_valid, ovr_err);
        end
        for (int k = 0; k < 32; k++) send_word(8'($urandom), 2, 2, 1'b1);
        checks++;
        if (ovr_err !== 1'b1) begin
            failures++;
            $display("FAIL ovr_err_set got=%b exp=1", ovr_err);
        end
        checks++;
        if ({plaintext, key} !== first) begin
            failures++;
            $display("FAIL ovr_held_block got=%h exp=%h", {plaintext, key}, first);
        end
        consume();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL ovr_single_transfer got valid=%b exp=0", out_valid);
        end
        clear_errs();
        checks++;
        if (ovr_err !== 1'b0) begin
            failures++;
            $display("FAIL ovr_err_clear got=%b exp=0", ovr_err);
        end
    endtask

    task automatic test_enable();
        send_start();
        for (int k = 0; k < 10; k++) send_word(8'($urandom), 2, 2, 1'b1);
        @(negedge clk);
        in_en = 1'b0;
        for (int k = 0; k < 5; k++) send_word(8'($urandom), 2, 2, 1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if (dut.count_q !== 5'd10) begin
            failures++;
            $display("FAIL enable_count_frozen got=%0d exp=10", dut.count_q);
        end
        in_en = 1'b1;
        for (int k = 0; k < 22; k++) send_word(8'($urandom), 2, 2, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || {plaintext, key} !== exp_blk) begin
            failures++;
            $display("FAIL enable_block got v=%b blk=%h exp=%h", out_valid, {plaintext, key}, exp_blk);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        send_start();
        for (int k = 0; k < 32; k++) send_word(8'($urandom), 2, 2, 1'b1);
        send_start();
        for (int k = 0; k < 17; k++) send_word(8'($urandom), 2, 2, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, short_err, ovr_err, plaintext, key} !== '0) begin
            failures++;
            $display("FAIL reset_async got v=%b pt=%h key=%h exp all zero", out_valid, plaintext, key);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        send_start();
        for (int k = 0; k < 32; k++) send_word(8'($urandom), 2, 2, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || short_err !== 1'b0 || {plaintext, key} !== exp_blk) begin
            failures++;
            $display("FAIL reset_fresh_block got v=%b s=%b blk=%h exp=%h",
                     out_valid, short_err, {plaintext, key}, exp_blk);
        end
    endtask

    task automatic test_no_start();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 9; k++) send_word(8'($urandom), 2, 2, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({out_valid2, plaintext2, key2} !== '0) begin
            failures++;
            $display("FAIL dut2_reset_async got v=%b pt=%h key=%h exp all zero", out_valid2, plaintext2, key2);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        exp_blk2 = '0;
        for (int k = 0; k < 16; k++) send_word(8'($urandom), 2, 2, 1'b1);
        checks++;
        if (out_valid2 !== 1'b1 || {plaintext2, key2} !== exp_blk2) begin
            failures++;
            $display("FAIL dut2_block got v=%b blk=%h exp=%h", out_valid2, {plaintext2, key2}, exp_blk2);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_ignores_words got valid=%b exp=0", out_valid);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        in_en     = 1'b1;
        start1    = 1'b0;
        load1     = 1'b0;
        part_msg1 = '0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        exp_blk   = '0;
        exp_blk2  = '0;
        test_reset();
        test_basic();
        test_long_hold();
        test_short_frame();
        test_simultaneous();
        test_overrun();
        test_enable();
        test_reset_mid();
        test_no_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
